// File: rtl/game_scoreboard.sv
// Match scoreboard fed by the counter's result flags.
// Edge-detects win/lose/gameover, keeps saturating tallies, holds the
// declared result until acknowledged, then raises a timed restart request.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_PLAY    | match running, tallies follow winner/loser rising edges
// S_DONE    | result held on result_code/result_valid until ack_i
// S_RESTART | restart_req high for HOLD_CYCLES cycles, then back to play
module game_scoreboard #(
  parameter int CNT_W       = 4,
  parameter int MAX_EVENTS  = 15,
  parameter int HOLD_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winner_i,
  input  logic             loser_i,
  input  logic             gameover_i,
  input  logic [1:0]       who_i,
  input  logic             clear_i,
  input  logic             ack_i,
  output logic [CNT_W-1:0] win_cnt,
  output logic [CNT_W-1:0] lose_cnt,
  output logic [1:0]       result_code,
  output logic             result_valid,
  output logic             restart_req,
  output logic             event_err
);

  typedef enum logic [1:0] {
    S_PLAY    = 2'd0,
    S_DONE    = 2'd1,
    S_RESTART = 2'd2
  } state_t;

  // A one-bit counter still works when only a single hold cycle is wanted.
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_EVENTS);
  localparam logic [CNT_W-1:0]  ONE_C     = CNT_W'(1);

  state_t            state, state_n;
  logic              winner_q, loser_q, gameover_q;
  logic [CNT_W-1:0]  win_n, lose_n;
  logic [1:0]        code_n;
  logic              err_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;

  logic              rise_win, rise_lose, rise_over;
  logic              win_inc, lose_inc;
  logic              win_hit, lose_hit;
  logic              who_ok;
  logic [CNT_W-1:0]  win_sum, lose_sum;

  assign rise_win  = winner_i & ~winner_q;
  assign rise_lose = loser_i & ~loser_q;
  assign rise_over = gameover_i & ~gameover_q;
  assign who_ok    = who_i[0] ^ who_i[1];

  // Saturating increments; a "hit" is only the step that lands on the limit.
  assign win_inc  = rise_win & (win_cnt != MAX_C);
  assign lose_inc = rise_lose & (lose_cnt != MAX_C);
  assign win_sum  = win_inc ? (win_cnt + ONE_C) : win_cnt;
  assign lose_sum = lose_inc ? (lose_cnt + ONE_C) : lose_cnt;
  assign win_hit  = win_inc & (win_sum == MAX_C);
  assign lose_hit = lose_inc & (lose_sum == MAX_C);

  assign result_valid = (state == S_DONE);
  assign restart_req  = (state == S_RESTART);

  // Input history; keeps tracking in every state so stale levels never re-count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winner_q   <= 1'b0;
      loser_q    <= 1'b0;
      gameover_q <= 1'b0;
    end else begin
      winner_q   <= winner_i;
      loser_q    <= loser_i;
      gameover_q <= gameover_i;
    end
  end

  // State, tallies, result and hold counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_PLAY;
      win_cnt     <= '0;
      lose_cnt    <= '0;
      result_code <= 2'b00;
      event_err   <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_n;
      win_cnt     <= win_n;
      lose_cnt    <= lose_n;
      result_code <= code_n;
      event_err   <= err_n;
      hold_cnt    <= hold_n;
    end
  end

  // Next-state and datapath decisions; clear_i overrides everything.
  always_comb begin
    state_n = state;
    win_n   = win_cnt;
    lose_n  = lose_cnt;
    code_n  = result_code;
    err_n   = 1'b0;
    hold_n  = hold_cnt;
    if (clear_i) begin
      state_n = S_PLAY;
      win_n   = '0;
      lose_n  = '0;
      code_n  = 2'b00;
      hold_n  = '0;
    end else begin
      case (state)
        S_PLAY: begin
          win_n  = win_sum;
          lose_n = lose_sum;
          if (rise_win && rise_lose) err_n = 1'b1;
          if (rise_over) begin
            state_n = S_DONE;
            if (who_ok) begin
              code_n = who_i;
            end else begin
              err_n = 1'b1;
              if (win_sum > lose_sum)      code_n = 2'b01;
              else if (lose_sum > win_sum) code_n = 2'b10;
              else                         code_n = 2'b00;
            end
          end else if (win_hit || lose_hit) begin
            state_n = S_DONE;
            if (win_hit && lose_hit) code_n = 2'b00;
            else if (win_hit)        code_n = 2'b01;
            else                     code_n = 2'b10;
          end
        end
        S_DONE: begin
          if (ack_i) begin
            state_n = S_RESTART;
            hold_n  = HOLD_INIT;
          end
        end
        S_RESTART: begin
          if (hold_cnt == '0) begin
            state_n = S_PLAY;
            win_n   = '0;
            lose_n  = '0;
            code_n  = 2'b00;
          end else begin
            hold_n = hold_cnt - HOLD_W'(1);
          end
        end
        default: begin
          state_n = S_PLAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_scoreboard.sv
// Bench for game_scoreboard: directed scenarios followed by random traffic,
// all cycle-checked against a behavioural model of the match rules.
module tb_game_scoreboard;

  localparam int CNT_W = 4;
  localparam int MAXE  = 15;
  localparam int HOLD  = 8;

  logic             clk, rst_n;
  logic             winner_i, loser_i, gameover_i, clear_i, ack_i;
  logic [1:0]       who_i;
  logic [CNT_W-1:0] win_cnt, lose_cnt;
  logic [1:0]       result_code;
  logic             result_valid, restart_req, event_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: phase 0 = playing, 1 = result held, 2 = restarting.
  int m_w, m_l, m_rc, m_phase, m_rem, m_err;
  bit m_wq, m_lq, m_gq;

  game_scoreboard #(.CNT_W(CNT_W), .MAX_EVENTS(MAXE), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n),
    .winner_i(winner_i), .loser_i(loser_i), .gameover_i(gameover_i),
    .who_i(who_i), .clear_i(clear_i), .ack_i(ack_i),
    .win_cnt(win_cnt), .lose_cnt(lose_cnt), .result_code(result_code),
    .result_valid(result_valid), .restart_req(restart_req), .event_err(event_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_checks++;
    assert (obs === 32'(exp))
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  task automatic model_reset();
    m_w = 0; m_l = 0; m_rc = 0; m_phase = 0; m_rem = 0; m_err = 0;
    m_wq = 0; m_lq = 0; m_gq = 0;
  endtask

  task automatic model_step(input bit w, l, g, input bit [1:0] who, input bit clr, ack);
    bit rw, rl, rg, wh, lh;
    int nw, nl;
    rw = w && !m_wq;
    rl = l && !m_lq;
    rg = g && !m_gq;
    m_err = 0;
    if (clr) begin
      m_phase = 0; m_w = 0; m_l = 0; m_rc = 0;
    end else if (m_phase == 0) begin
      nw = (m_w + rw > MAXE) ? MAXE : m_w + rw;
      nl = (m_l + rl > MAXE) ? MAXE : m_l + rl;
      wh = (nw == MAXE) && (m_w < MAXE);
      lh = (nl == MAXE) && (m_l < MAXE);
      if (rw && rl) m_err = 1;
      if (rg && (who == 2'd1 || who == 2'd2)) begin
        m_rc = who; m_phase = 1;
      end else if (rg) begin
        m_err = 1; m_phase = 1;
        m_rc = (nw > nl) ? 1 : ((nl > nw) ? 2 : 0);
      end else if (wh || lh) begin
        m_phase = 1;
        m_rc = (wh && lh) ? 0 : (wh ? 1 : 2);
      end
      m_w = nw; m_l = nl;
    end else if (m_phase == 1) begin
      if (ack) begin m_phase = 2; m_rem = HOLD; end
    end else begin
      m_rem--;
      if (m_rem == 0) begin m_phase = 0; m_w = 0; m_l = 0; m_rc = 0; end
    end
    m_wq = w; m_lq = l; m_gq = g;
  endtask

  task automatic check_model();
    chk("win_cnt", win_cnt, m_w);
    chk("lose_cnt", lose_cnt, m_l);
    chk("result_code", result_code, m_rc);
    chk("result_valid", result_valid, (m_phase == 1) ? 1 : 0);
    chk("restart_req", restart_req, (m_phase == 2) ? 1 : 0);
    chk("event_err", event_err, m_err);
  endtask

  task automatic cyc(input bit w, l, g, input bit [1:0] who, input bit clr, ack);
    winner_i = w; loser_i = l; gameover_i = g; who_i = who; clear_i = clr; ack_i = ack;
    @(posedge clk);
    model_step(w, l, g, who, clr, ack);
    #1;
    check_model();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 2'd0, 0, 0);
  endtask

  task automatic win_rise();
    cyc(1, 0, 0, 2'd0, 0, 0);
    idle();
  endtask

  task automatic lose_rise();
    cyc(0, 1, 0, 2'd0, 0, 0);
    idle();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_win"}, win_cnt, 0);
    chk({tag, "_lose"}, lose_cnt, 0);
    chk({tag, "_code"}, result_code, 0);
    chk({tag, "_valid"}, result_valid, 0);
    chk({tag, "_restart"}, restart_req, 0);
    chk({tag, "_err"}, event_err, 0);
  endtask

  int n_req;

  initial begin
    rst_n = 1'b0;
    winner_i = 0; loser_i = 0; gameover_i = 0; who_i = 2'd0; clear_i = 0; ack_i = 0;
    model_reset();
    #22;
    check_zero("reset");
    rst_n = 1'b1;

    // Three winner and two loser rises, each two cycles high and two low.
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 2'd0, 0, 0); cyc(1, 0, 0, 2'd0, 0, 0); idle(); idle();
    end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 0, 2'd0, 0, 0); cyc(0, 1, 0, 2'd0, 0, 0); idle(); idle();
    end
    chk("basic_win", win_cnt, 3);
    chk("basic_lose", lose_cnt, 2);
    chk("basic_valid", result_valid, 0);

    // Level held high counts once; then saturate to end the match.
    cyc(0, 0, 0, 2'd0, 1, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 2'd0, 0, 0);
    idle();
    chk("level_once", win_cnt, 1);
    for (int i = 0; i < 13; i++) win_rise();
    cyc(1, 0, 0, 2'd0, 0, 0);
    chk("sat_win", win_cnt, 15);
    chk("sat_code", result_code, 1);
    chk("sat_valid", result_valid, 1);
    idle(); win_rise();
    chk("done_frozen", win_cnt, 15);

    // Acknowledge: restart window length, and a winner rise inside it is dropped.
    cyc(0, 0, 0, 2'd0, 0, 1);
    chk("ack_valid_drop", result_valid, 0);
    n_req = restart_req;
    for (int i = 0; i < 11; i++) begin
      cyc((i == 2), 0, 0, 2'd0, 0, 0);
      n_req += restart_req;
    end
    chk("restart_len", n_req, HOLD);
    chk("restart_win0", win_cnt, 0);
    chk("restart_code0", result_code, 0);

    // Gameover with explicit WHO = loser side at 4/6.
    for (int i = 0; i < 4; i++) win_rise();
    for (int i = 0; i < 6; i++) lose_rise();
    cyc(0, 0, 1, 2'd2, 0, 0);
    chk("go_who_code", result_code, 2);
    chk("go_who_valid", result_valid, 1);
    chk("go_who_err", event_err, 0);

    // Clear while holding the result, then count afresh.
    cyc(0, 0, 0, 2'd0, 1, 0);
    check_zero("clear_done");
    win_rise();
    chk("after_clear", win_cnt, 1);

    // Gameover with invalid WHO at 5/2: decided by tallies, error pulse.
    cyc(0, 0, 0, 2'd0, 1, 0);
    for (int i = 0; i < 5; i++) win_rise();
    for (int i = 0; i < 2; i++) lose_rise();
    cyc(0, 0, 1, 2'd3, 0, 0);
    chk("go_bad_code", result_code, 1);
    chk("go_bad_err", event_err, 1);
    idle();
    chk("err_is_pulse", event_err, 0);

    // Async reset in the middle of the restart window.
    cyc(0, 0, 0, 2'd0, 0, 1);
    idle(); idle(); idle();
    chk("mid_restart_req", restart_req, 1);
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    #2;
    rst_n = 1'b1;
    cyc(1, 0, 0, 2'd0, 0, 0);
    chk("after_rst", win_cnt, 1);
    idle();

    // Simultaneous rises at 14/14 reach the limit together.
    cyc(0, 0, 0, 2'd0, 1, 0);
    for (int i = 0; i < 14; i++) begin win_rise(); lose_rise(); end
    cyc(1, 1, 0, 2'd0, 0, 0);
    chk("tie_win", win_cnt, 15);
    chk("tie_lose", lose_cnt, 15);
    chk("tie_code", result_code, 0);
    chk("tie_err", event_err, 1);
    chk("tie_valid", result_valid, 1);

    // Random traffic against the model.
    cyc(0, 0, 0, 2'd0, 1, 0);
    for (int i = 0; i < 3000; i++) begin
      cyc(bit'($urandom % 2), bit'($urandom % 2), ($urandom % 12) == 0,
          2'($urandom % 4), ($urandom % 80) == 0, ($urandom % 6) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
